mux_sel_arbiter: RTL and testbench
==================================

Name: mux_sel_arbiter

Overview:
- Round-robin arbiter that shares the 5-input select mux (Hyrja0..Hyrja4 -> Dalja, 3-bit select S) between five requesting sources on the CPU's internal bus.
- Accepts one request line per source, grants exactly one owner at a time, and drives the mux select S so that the owner's input reaches Dalja.
- Sits beside the mux in the CPU datapath; the control unit and peripherals raise requests, and the arbiter sequences ownership.

Parameters:
- NUM_REQ, 5, number of requesters. Fixed to match the mux inputs; other values are unsupported.
- SEL_W, 3, width of the select output S.
- MAX_HOLD, 8, maximum consecutive owned cycles before preemption. Used only when ARB_TIMEOUT_EN is defined; legal range 1..255.

Ports:
- Clock, input, 1: single system clock; all state is updated on the rising edge.
- Reset, input, 1: asynchronous, active-low reset. Assertion clears all state immediately; deassertion is synchronous to Clock.
- Req, input, 5: Req[i] = 1 means source i requests the mux. Level-sensitive; the source holds it for its whole transfer.
- Grant, output, 5: one-hot owner indication, or all zero when there is no owner.
- Valid, output, 1: 1 while an owner exists (equal to OR of Grant).
- S, output, 3: mux select, equal to the owner index 0..4. Holds the last owner index while idle. Never takes values 5..7.
- Timeout, output, 1: present only with ARB_TIMEOUT_EN. One-cycle pulse when a preemption occurs.

Behaviour:
- Reset values: Grant = 5'b00000, Valid = 0, S = 3'd0, Timeout = 0. The internal last-owner pointer = 4, so requester 0 has first priority after reset.
- Two states: IDLE (no owner) and OWNED.
- IDLE:
  - If Req != 0 at a rising edge, select the first set bit searching from (last+1) mod 5 with wrap-around (4 -> 0).
  - On that same edge: Grant = one-hot(winner), S = winner, Valid = 1, last = winner; go to OWNED.
  - Latency from Req rising to Grant is 1 cycle.
- OWNED, owner's Req still 1: hold Grant and S unchanged, regardless of other requests.
- OWNED, owner's Req sampled 0 (release):
  - Search the other requesters from (owner+1) mod 5. The owner's own bit is excluded because it is 0.
  - If one is found, grant it on the same edge. Handover has no idle bubble: Grant changes directly from one one-hot value to the next, and Valid stays 1.
  - If none is found, Grant = 0 and Valid = 0, S holds the last value, and the state returns to IDLE.
- Simultaneous requests: resolved by round-robin order only; no source has fixed priority.
- Combinational properties: Grant is never multi-hot, and S always equals the index of the set Grant bit whenever Valid = 1.
- A requester that drops Req before being granted is simply not selected; no memory of past requests is kept.
- Reset asserted mid-ownership: outputs return to reset values asynchronously, and any in-flight transfer is abandoned.
- Req bits for nonexistent sources: none exist, since the width is exactly 5.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter clears on every new grant and increments each OWNED cycle.
  - When the counter reaches MAX_HOLD and any other Req bit is 1, the arbiter preempts: it grants the next requester in round-robin order from owner+1 on that edge and pulses Timeout for 1 cycle.
  - The preempted source loses Grant even though its Req is still high, and must wait for its next round-robin turn.
  - With no other request pending, the counter saturates at MAX_HOLD and the owner keeps the mux.
- Undefined: no counter, no Timeout port, and ownership is unbounded.

Decomposition:
- Shared package (cpu_pkg) holds:
  - REQ_N = 5 and SEL_W = 3.
  - State encoding: ST_IDLE = 1'b0, ST_OWNED = 1'b1.
  - Source index constants: SRC_ALU = 0, SRC_REG = 1, SRC_MEM = 2, SRC_IMM = 3, SRC_IO = 4.
- One sub-module: rr_pick5, a purely combinational search.
  - Inputs: Req[4:0], start index[2:0].
  - Outputs: found, winner[2:0].
  - Instantiated once and reused for the IDLE, release and preemption paths.

Test Plan:
- Reset, then Req = 5'b00001 -> one cycle later Grant = 5'b00001, S = 0, Valid = 1. Assert Reset mid-grant -> Grant = 0, S = 0, Valid = 0 immediately.
- Req = 5'b11111 held, each owner releasing for one cycle after 2 owned cycles -> grant order 0, 1, 2, 3, 4, 0, with S tracking and no idle cycle between owners.
- Owner 4 holds while Req = 5'b10010, then 4 releases -> Grant = 5'b00010 (wrap-around past 0), S = 1, Valid stays 1.
- Sole owner 2 releases with Req = 0 -> Grant = 0, Valid = 0, S stays 2. A later Req = 5'b00100 -> owner 2 again after 1 cycle.
- ARB_TIMEOUT_EN with MAX_HOLD = 8: owner 0 holds while Req[3] = 1 -> after 8 owned cycles Grant = 5'b01000, S = 3, Timeout = 1 for one cycle. Same run with only Req[0] high -> no preemption, Timeout stays 0.
- Random Req for 10k cycles -> Grant is always one-hot or zero, S always ≤ 4, and S matches the Grant index whenever Valid = 1.

Source files
------------

// File: rtl/cpu_pkg.sv
// ============================================================================
//  Package     : cpu_pkg
//  Description : Shared constants, state encoding and helpers for the
//                five-source mux select arbiter (mux_sel_arbiter).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    // Requester count and select width of the shared 5-input mux
    localparam int REQ_N = 5;
    localparam int SEL_W = 3;

    // Arbiter ownership states
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_t;

    // Mux input index of each bus source
    localparam logic [SEL_W-1:0] SRC_ALU = 3'd0;
    localparam logic [SEL_W-1:0] SRC_REG = 3'd1;
    localparam logic [SEL_W-1:0] SRC_MEM = 3'd2;
    localparam logic [SEL_W-1:0] SRC_IMM = 3'd3;
    localparam logic [SEL_W-1:0] SRC_IO  = 3'd4;

    // Round-robin successor of a source index, wrapping 4 -> 0
    function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] idx);
        return (idx == SRC_IO) ? SRC_ALU : idx + 3'd1;
    endfunction

    // One-hot grant vector for a source index
    function automatic logic [REQ_N-1:0] onehot5(input logic [SEL_W-1:0] idx);
        logic [REQ_N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage : cpu_pkg

`default_nettype wire

// File: rtl/mux_sel_arbiter_rr_pick5.sv
// ============================================================================
//  Module      : rr_pick5
//  Description : Combinational round-robin search over five request bits.
//                Returns the first set bit found starting at i_start and
//                walking upward with wrap-around from 4 to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick5
    import cpu_pkg::*;
(
    input  logic [REQ_N-1:0] i_req,
    input  logic [SEL_W-1:0] i_start,
    output logic             o_found,
    output logic [SEL_W-1:0] o_winner
);

    logic [SEL_W-1:0] pos;

    // Walk the five positions in round-robin order; the first hit wins
    always_comb begin
        o_found  = 1'b0;
        o_winner = '0;
        pos      = i_start;
        for (int k = 0; k < REQ_N; k++) begin
            if (!o_found && i_req[pos]) begin
                o_found  = 1'b1;
                o_winner = pos;
            end
            pos = next_idx(pos);
        end
    end

endmodule : rr_pick5

`default_nettype wire

// File: rtl/mux_sel_arbiter.sv
// ============================================================================
//  Module      : mux_sel_arbiter
//  Description : Round-robin owner arbiter for the shared 5-input select mux.
//                Grants one requester at a time, drives the mux select S with
//                the owner index, and hands over without an idle bubble.
//                Optional macro ARB_TIMEOUT_EN adds a hold counter that
//                preempts an owner after MAX_HOLD cycles when others wait,
//                together with the o_timeout pulse output.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_sel_arbiter #(
    parameter int NUM_REQ  = 5,     // fixed at 5 to match the mux inputs
    parameter int SEL_W    = 3
`ifdef ARB_TIMEOUT_EN
   ,parameter int MAX_HOLD = 8      // legal range 1..255
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] i_req,
    output logic [NUM_REQ-1:0] o_grant,
    output logic               o_valid,
    output logic [SEL_W-1:0]   o_s
`ifdef ARB_TIMEOUT_EN
   ,output logic               o_timeout
`endif
);

    import cpu_pkg::*;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [SEL_W-1:0]   sel_q,   sel_d;
    logic [SEL_W-1:0]   last_q,  last_d;

    logic [NUM_REQ-1:0] pick_req;
    logic [SEL_W-1:0]   pick_start;
    logic               pick_found;
    logic [SEL_W-1:0]   pick_winner;
    logic               take;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_MAX  = 8'(MAX_HOLD);
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] hold_q, hold_d;
    logic       timeout_q, timeout_d;
`endif

    // The current owner is masked out, so one search serves the idle,
    // release and preemption paths; last_q equals the owner while OWNED.
    assign pick_req   = i_req & ~grant_q;
    assign pick_start = next_idx(last_q);

    rr_pick5 u_pick (
        .i_req    (pick_req),
        .i_start  (pick_start),
        .o_found  (pick_found),
        .o_winner (pick_winner)
    );

    // Next-state and grant decision
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        last_d  = last_q;
        take    = 1'b0;
`ifdef ARB_TIMEOUT_EN
        hold_d    = hold_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                take = pick_found;
            end
            ST_OWNED: begin
                if (!i_req[sel_q]) begin
                    // Owner released: hand over directly or go idle
                    if (pick_found) begin
                        take = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                else if (hold_q >= HOLD_LAST && pick_found) begin
                    // Owner exceeded its hold budget while others wait
                    take      = 1'b1;
                    timeout_d = 1'b1;
                end else if (hold_q != HOLD_MAX) begin
                    hold_d = hold_q + 8'd1;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase

        if (take) begin
            state_d = ST_OWNED;
            grant_d = onehot5(pick_winner);
            sel_d   = pick_winner;
            last_d  = pick_winner;
`ifdef ARB_TIMEOUT_EN
            hold_d  = '0;
`endif
        end
    end

    // State register; last pointer resets to 4 so source 0 goes first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            sel_q   <= SRC_ALU;
            last_q  <= SRC_IO;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Hold counter and preemption pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_timeout = timeout_q;
`endif

    assign o_grant = grant_q;
    assign o_valid = |grant_q;
    assign o_s     = sel_q;

endmodule : mux_sel_arbiter

`default_nettype wire

// File: tb/tb_mux_sel_arbiter.sv
// ============================================================================
//  Module      : tb_mux_sel_arbiter
//  Description : Self-checking bench for mux_sel_arbiter: directed vector
//                table, reset and timeout sequences, and a randomized run
//                checked against a behavioural round-robin model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_sel_arbiter;

    localparam int MAXH = 8;

    logic       clk;
    logic       rst_n;
    logic [4:0] i_req;
    logic [4:0] o_grant;
    logic       o_valid;
    logic [2:0] o_s;
`ifdef ARB_TIMEOUT_EN
    logic       o_timeout;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    int m_owner;   // -1 when nobody owns the mux
    int m_last;
    int m_s;
    int m_held;
    bit m_tmo;

    typedef struct {
        logic [4:0] req;
        logic [4:0] grant;
        logic [2:0] s;
        logic       valid;
    } vec_t;

    vec_t vecs[21];

    mux_sel_arbiter #(
        .NUM_REQ  (5),
        .SEL_W    (3)
`ifdef ARB_TIMEOUT_EN
       ,.MAX_HOLD (MAXH)
`endif
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req    (i_req),
        .o_grant  (o_grant),
        .o_valid  (o_valid),
        .o_s      (o_s)
`ifdef ARB_TIMEOUT_EN
       ,.o_timeout(o_timeout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // First set bit of r searching upward from index 'from' with wrap
    function automatic int rr_search(input logic [4:0] r, input int from);
        for (int k = 0; k < 5; k++) begin
            if (r[(from + k) % 5]) return (from + k) % 5;
        end
        return -1;
    endfunction

    function automatic logic [4:0] model_grant();
        logic [4:0] g;
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last  = 4;
        m_s     = 0;
        m_held  = 0;
        m_tmo   = 1'b0;
    endtask

    task automatic model_give(input int w);
        m_owner = w;
        m_last  = w;
        m_s     = w;
        m_held  = 0;
    endtask

    // One rising edge of the reference arbiter
    task automatic model_step(input logic [4:0] r);
        int w;
        logic [4:0] others;
        m_tmo = 1'b0;
        if (m_owner < 0) begin
            w = rr_search(r, (m_last + 1) % 5);
            if (w >= 0) model_give(w);
        end else if (!r[m_owner]) begin
            w = rr_search(r, (m_owner + 1) % 5);
            if (w >= 0) model_give(w);
            else        m_owner = -1;
        end else begin
            m_held++;
`ifdef ARB_TIMEOUT_EN
            if (m_held >= MAXH) begin
                others = r;
                others[m_owner] = 1'b0;
                w = rr_search(others, (m_owner + 1) % 5);
                if (w >= 0) begin
                    model_give(w);
                    m_tmo = 1'b1;
                end
            end
`else
            others = '0;
`endif
        end
    endtask

    // Drive a request pattern through one clock edge, sample 1 time unit later
    task automatic cycle(input logic [4:0] r);
        i_req = r;
        @(posedge clk);
        model_step(r);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        i_req = '0;
        model_reset();
        @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_grant"}, 32'(o_grant), 32'(model_grant()));
        check({tag, "_s"},     32'(o_s),     32'(m_s));
        check({tag, "_valid"}, 32'(o_valid), 32'(m_owner >= 0));
`ifdef ARB_TIMEOUT_EN
        check({tag, "_timeout"}, 32'(o_timeout), 32'(m_tmo));
`endif
    endtask

    initial begin
        logic [4:0] r;

        //             req       grant     s     valid
        vecs[0]  = '{5'b11111, 5'b00001, 3'd0, 1'b1};
        vecs[1]  = '{5'b11111, 5'b00001, 3'd0, 1'b1};
        vecs[2]  = '{5'b11110, 5'b00010, 3'd1, 1'b1};
        vecs[3]  = '{5'b11111, 5'b00010, 3'd1, 1'b1};
        vecs[4]  = '{5'b11101, 5'b00100, 3'd2, 1'b1};
        vecs[5]  = '{5'b11111, 5'b00100, 3'd2, 1'b1};
        vecs[6]  = '{5'b11011, 5'b01000, 3'd3, 1'b1};
        vecs[7]  = '{5'b11111, 5'b01000, 3'd3, 1'b1};
        vecs[8]  = '{5'b10111, 5'b10000, 3'd4, 1'b1};
        vecs[9]  = '{5'b11111, 5'b10000, 3'd4, 1'b1};
        vecs[10] = '{5'b01111, 5'b00001, 3'd0, 1'b1};
        vecs[11] = '{5'b10000, 5'b10000, 3'd4, 1'b1};
        vecs[12] = '{5'b10010, 5'b10000, 3'd4, 1'b1};
        vecs[13] = '{5'b00010, 5'b00010, 3'd1, 1'b1};
        vecs[14] = '{5'b00000, 5'b00000, 3'd1, 1'b0};
        vecs[15] = '{5'b00100, 5'b00100, 3'd2, 1'b1};
        vecs[16] = '{5'b00000, 5'b00000, 3'd2, 1'b0};
        vecs[17] = '{5'b00000, 5'b00000, 3'd2, 1'b0};
        vecs[18] = '{5'b00100, 5'b00100, 3'd2, 1'b1};
        vecs[19] = '{5'b00000, 5'b00000, 3'd2, 1'b0};
        vecs[20] = '{5'b01001, 5'b01000, 3'd3, 1'b1};

        rst_n = 1'b0;
        i_req = '0;
        #2;
        // Reset values
        check("rst_grant", 32'(o_grant), 32'h0);
        check("rst_valid", 32'(o_valid), 32'h0);
        check("rst_s",     32'(o_s),     32'h0);
`ifdef ARB_TIMEOUT_EN
        check("rst_timeout", 32'(o_timeout), 32'h0);
`endif
        do_reset();

        // First grant one cycle after request, then asynchronous reset mid-grant
        cycle(5'b00001);
        check("first_grant", 32'(o_grant), 32'h01);
        check("first_s",     32'(o_s),     32'h0);
        check("first_valid", 32'(o_valid), 32'h1);
        cycle(5'b00111);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_grant", 32'(o_grant), 32'h0);
        check("async_rst_valid", 32'(o_valid), 32'h0);
        check("async_rst_s",     32'(o_s),     32'h0);
        do_reset();

        // Directed table: rotation, wrap-around handover, idle and regrant
        for (int i = 0; i < 21; i++) begin
            cycle(vecs[i].req);
            check($sformatf("vec%0d_grant", i), 32'(o_grant), 32'(vecs[i].grant));
            check($sformatf("vec%0d_s", i),     32'(o_s),     32'(vecs[i].s));
            check($sformatf("vec%0d_valid", i), 32'(o_valid), 32'(vecs[i].valid));
        end

`ifdef ARB_TIMEOUT_EN
        // Preemption after MAX_HOLD owned cycles while source 3 waits
        do_reset();
        cycle(5'b00001);
        for (int i = 1; i < MAXH; i++) begin
            cycle(5'b01001);
            check("hold_grant", 32'(o_grant), 32'h01);
            check("hold_tmo",   32'(o_timeout), 32'h0);
        end
        cycle(5'b01001);
        check("preempt_grant", 32'(o_grant), 32'h08);
        check("preempt_s",     32'(o_s),     32'h3);
        check("preempt_tmo",   32'(o_timeout), 32'h1);
        cycle(5'b01001);
        check("after_preempt_grant", 32'(o_grant), 32'h08);
        check("after_preempt_tmo",   32'(o_timeout), 32'h0);

        // Lone owner keeps the mux indefinitely
        do_reset();
        for (int i = 0; i < 3 * MAXH; i++) begin
            cycle(5'b00001);
            check("lone_grant", 32'(o_grant), 32'h01);
            check("lone_tmo",   32'(o_timeout), 32'h0);
        end
`endif

        // Randomized run against the reference model plus invariants
        do_reset();
        r = '0;
        for (int c = 0; c < 10000; c++) begin
            for (int b = 0; b < 5; b++) begin
                if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
            end
            cycle(r);
            check_model("rand");
            check("rand_onehot0", 32'($onehot0(o_grant)), 32'h1);
            check("rand_s_range", 32'(o_s <= 3'd4), 32'h1);
            if (o_valid) check("rand_s_match", 32'(o_grant[o_s]), 32'h1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_mux_sel_arbiter

`default_nettype wire
